// File: rtl/tone_pkg.sv
// Shared types, divisor constants and note-code decoding for the tone sequencer.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LIVE,
        SONG
    } state_t;

    typedef logic [2:0] note_t;

    localparam int unsigned CLK_HZ = 100000;

    localparam logic [7:0] DIV_A4 = 8'd112;
    localparam logic [7:0] DIV_B4 = 8'd100;
    localparam logic [7:0] DIV_C5 = 8'd94;
    localparam logic [7:0] DIV_D5 = 8'd84;
    localparam logic [7:0] DIV_E5 = 8'd74;
    localparam logic [7:0] DIV_F5 = 8'd70;
    localparam logic [7:0] DIV_G5 = 8'd62;

    // Code 0 is a rest; it decodes to 0 and is never enabled.
    function automatic logic [7:0] note_div(input note_t code);
        logic [7:0] d;
        case (code)
            3'd1:    d = DIV_A4;
            3'd2:    d = DIV_B4;
            3'd3:    d = DIV_C5;
            3'd4:    d = DIV_D5;
            3'd5:    d = DIV_E5;
            3'd6:    d = DIV_F5;
            3'd7:    d = DIV_G5;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/note_rom.sv
// Combinational 8-step melody table; swap the contents here to change the tune.
module note_rom
    import tone_pkg::*;
(
    input  logic [2:0] addr,
    output note_t      code
);

    always_comb begin
        case (addr)
            3'd0:    code = 3'd3;
            3'd1:    code = 3'd4;
            3'd2:    code = 3'd5;
            3'd3:    code = 3'd3;
            3'd4:    code = 3'd0;
            3'd5:    code = 3'd7;
            3'd6:    code = 3'd5;
            default: code = 3'd1;
        endcase
    end

endmodule

// File: rtl/tone_sequencer.sv
// Tone generator control: live keys override an 8-step ROM melody.
// Define TONE_SEQ_GAP_EN to silence the tail of each melody step.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned STEP_TICKS = 25000,
    parameter int unsigned GAP_TICKS  = 2500,
    parameter int unsigned DIV_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       keys,
    input  logic             play,
    input  logic             loop,
    output logic [DIV_W-1:0] tone_div,
    output logic             tone_en,
    output logic             busy,
    output logic [2:0]       step
);

    localparam int unsigned    TW        = $clog2(STEP_TICKS);
    localparam logic [TW-1:0]  TICK_LAST = TW'(STEP_TICKS - 1);

    state_t        state;
    logic [TW-1:0] tick;
    logic [TW-1:0] tick_nxt;
    logic [2:0]    step_nxt;
    logic          tick_last;
    logic          song_end;
    logic          in_gap;
    note_t         song_code;
    note_t         key_code;

    note_rom u_rom (
        .addr (step_nxt),
        .code (song_code)
    );

    // Outputs are registered, so the ROM is addressed with the step the
    // registers are about to hold rather than the current one.
    always_comb begin
        tick_last = (tick == TICK_LAST);
        song_end  = tick_last && (step == 3'd7) && !loop;
        tick_nxt  = '0;
        step_nxt  = '0;
        if (state == SONG) begin
            tick_nxt = tick_last ? '0 : tick + 1'b1;
            step_nxt = tick_last ? step + 3'd1 : step;
        end
`ifdef TONE_SEQ_GAP_EN
        in_gap = (tick_nxt >= TW'(STEP_TICKS - GAP_TICKS));
`else
        in_gap = 1'b0;
`endif
    end

    // Lowest bit scanned first so the highest asserted bit (A4) wins.
    always_comb begin
        key_code = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (keys[i]) key_code = note_t'(7 - i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick     <= '0;
            step     <= '0;
            tone_div <= '0;
            tone_en  <= 1'b0;
            busy     <= 1'b0;
        end else if (|keys) begin
            state    <= LIVE;
            tick     <= '0;
            step     <= '0;
            tone_div <= DIV_W'(note_div(key_code));
            tone_en  <= 1'b1;
            busy     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (play) begin
                        state    <= SONG;
                        tick     <= '0;
                        step     <= '0;
                        tone_div <= DIV_W'(note_div(song_code));
                        tone_en  <= (song_code != '0) && !in_gap;
                        busy     <= 1'b1;
                    end else begin
                        tone_div <= '0;
                        tone_en  <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                SONG: begin
                    if (song_end) begin
                        state    <= IDLE;
                        tick     <= '0;
                        step     <= '0;
                        tone_div <= '0;
                        tone_en  <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        tick     <= tick_nxt;
                        step     <= step_nxt;
                        tone_div <= DIV_W'(note_div(song_code));
                        tone_en  <= (song_code != '0) && !in_gap;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick     <= '0;
                    step     <= '0;
                    tone_div <= '0;
                    tone_en  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer with a short step length.
module tb_tone_sequencer;

    localparam int unsigned ST = 4;
    localparam int unsigned GT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] keys = '0;
    logic       play = 1'b0;
    logic       loop = 1'b0;
    logic [7:0] tone_div;
    logic       tone_en;
    logic       busy;
    logic [2:0] step;

    tone_sequencer #(
        .STEP_TICKS (ST),
        .GAP_TICKS  (GT),
        .DIV_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keys     (keys),
        .play     (play),
        .loop     (loop),
        .tone_div (tone_div),
        .tone_en  (tone_en),
        .busy     (busy),
        .step     (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] vec;
        logic [12:0] mask;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    logic [12:0] actual;
    assign actual = {tone_div, tone_en, busy, step};

    logic [7:0] div_tab [8] = '{8'd0, 8'd112, 8'd100, 8'd94, 8'd84, 8'd74, 8'd70, 8'd62};
    logic [2:0] melody  [8] = '{3'd3, 3'd4, 3'd5, 3'd3, 3'd0, 3'd7, 3'd5, 3'd1};

    localparam logic [12:0] ALL     = 13'h1FFF;
    localparam logic [12:0] NO_STEP = 13'h1FF8;

    function automatic exp_t mk(input logic [7:0] d, input logic en, input logic b,
                                input logic [2:0] s, input logic chk_step, input string n);
        exp_t x;
        x.vec  = {d, en, b, chk_step ? s : 3'd0};
        x.mask = chk_step ? ALL : NO_STEP;
        x.name = n;
        return x;
    endfunction

    // Expected outputs i cycles after the play edge of an uninterrupted song.
    function automatic exp_t song_exp(input int i, input string n);
        int unsigned s = (i / ST) % 8;
        int unsigned t = i % ST;
        logic [2:0] c = melody[s];
        logic en = (c != 3'd0);
`ifdef TONE_SEQ_GAP_EN
        if (t >= ST - GT) en = 1'b0;
`else
        if (t > ST) en = 1'b0;
`endif
        return mk(div_tab[c], en, 1'b1, 3'(s), 1'b1, n);
    endfunction

    task automatic drive(input logic r, input logic [6:0] k, input logic p, input logic l);
        @(negedge clk);
        rst  = r;
        keys = k;
        play = p;
        loop = l;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, 7'h7F, 1'b0, 1'b0);
            if (i < 2) exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 3'd0, 1'b1, "reset"));
            else       exp_q.push_back(mk(8'd112, 1'b1, 1'b1, 3'd0, 1'b0, "post_reset_live"));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ((actual & e.mask) !== e.vec) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, actual & e.mask, e.vec);
            end
        end
    endtask

    task automatic test_live;
        logic [6:0] kv [9] = '{7'b0000011, 7'b0010100, 7'b0000000, 7'b0000001,
                               7'b1000001, 7'b0000000, 7'b0001000, 7'b0000000, 7'b0000000};
        logic       pv [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] dv [9] = '{8'd70, 8'd94, 8'd0, 8'd62, 8'd112, 8'd0, 8'd84, 8'd0, 8'd0};
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, kv[i], pv[i], 1'b0);
            exp_q.push_back(mk(dv[i], kv[i] != 0, kv[i] != 0, 3'd0, 1'b0,
                               $sformatf("live_%0d", i)));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ((actual & e.mask) !== e.vec) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, actual & e.mask, e.vec);
            end
        end
    endtask

    // Stray play pulse and a loop blip mid-song must both be ignored.
    task automatic test_song_once;
        for (int i = 0; i < 34; i++) begin
            drive(1'b0, 7'd0, (i == 0) || (i == 5), (i >= 10) && (i <= 20));
            if (i < 8 * ST) exp_q.push_back(song_exp(i, $sformatf("song_%0d", i)));
            else exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 3'd0, 1'b0, $sformatf("song_end_%0d", i)));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ((actual & e.mask) !== e.vec) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, actual & e.mask, e.vec);
            end
        end
    endtask

    task automatic test_loop_abort;
        for (int i = 0; i < 45; i++) begin
            if (i < 40) begin
                drive(1'b0, 7'd0, i == 0, 1'b1);
                exp_q.push_back(song_exp(i, $sformatf("loop_%0d", i)));
            end else if (i == 40) begin
                drive(1'b0, 7'b1000000, 1'b0, 1'b1);
                exp_q.push_back(mk(8'd112, 1'b1, 1'b1, 3'd0, 1'b1, "abort_live"));
            end else begin
                drive(1'b0, 7'd0, 1'b0, 1'b1);
                exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 3'd0, 1'b0, $sformatf("no_resume_%0d", i)));
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ((actual & e.mask) !== e.vec) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, actual & e.mask, e.vec);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                drive(1'b0, 7'd0, i == 0, 1'b0);
                exp_q.push_back(song_exp(i, $sformatf("pre_rst_%0d", i)));
            end else begin
                drive(i == 6, (i == 6) ? 7'b0000100 : 7'd0, 1'b0, 1'b0);
                exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 3'd0, 1'b1, $sformatf("mid_rst_%0d", i)));
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ((actual & e.mask) !== e.vec) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, actual & e.mask, e.vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_live();
        test_song_once();
        test_loop_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
